// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
//
// Tracks the destination register of every in-flight instruction (EX, MEM, WB, RET).
// Drives the rs1/rs2 forwarding mux selects. Generates the PC/IF-ID hold (stall),
// inserts load-use bubbles and sequences the flush that follows a branch mispredict.
// All datapath muxes live outside this block.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   id_valid       in   ID holds a real instruction
//   id_rs1/id_rs2  in   source register indices of the ID instruction
//   id_use_rs1/2   in   ID instruction actually reads rs1/rs2
//   id_rd          in   destination register index of the ID instruction
//   id_regwen      in   ID instruction writes rd
//   id_is_load     in   ID instruction is a load
//   ex_mispredict  in   EX resolved a branch/jump against the prediction
//   mem_wait       in   data memory not ready, freezes the whole pipeline
//   fwd_sel_rs1/2  out  forward select for the instruction in EX:
//                       00 regfile, 01 EX/MEM ALU, 10 MEM/WB writeback, 11 RET register
//   stall          out  hold PC and the IF/ID register
//   bubble         out  load a NOP into the ID/EX register
//   flush_if_id    out  invalidate the IF/ID register
//   flush_id_ex    out  invalidate the ID/EX register

module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,  // 1..7
    parameter int unsigned XLEN_REG     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [XLEN_REG-1:0] id_rs1,
    input  logic [XLEN_REG-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [XLEN_REG-1:0] id_rd,
    input  logic                id_regwen,
    input  logic                id_is_load,
    input  logic                ex_mispredict,
    input  logic                mem_wait,
    output logic [1:0]          fwd_sel_rs1,
    output logic [1:0]          fwd_sel_rs2,
    output logic                stall,
    output logic                bubble,
    output logic                flush_if_id,
    output logic                flush_id_ex
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN_REG-1:0] rd;
        logic                regwen;
        logic                is_load;
    } trk_t;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    trk_t       ex_q, mem_q, wb_q, ret_q;
    trk_t       ex_d;
    logic [1:0] sel1_q, sel2_q, sel1_d, sel2_d;
    logic       advance;
    logic       take_id;
    logic       load_use;
    logic       flush;

    // Stage t produces the value of rs for the consumer.
    function automatic logic hit(input trk_t t, input logic [XLEN_REG-1:0] rs,
                                 input logic use_rs);
        return use_rs && t.valid && t.regwen && (t.rd != '0) && (t.rd == rs);
    endfunction

    // Youngest producer wins: current EX becomes MEM (01), MEM becomes WB (10), WB becomes RET (11).
    function automatic logic [1:0] pick(input trk_t ex, input trk_t mem, input trk_t wb,
                                        input logic [XLEN_REG-1:0] rs, input logic use_rs);
        if (hit(ex, rs, use_rs)) begin
            return 2'b01;
        end else if (hit(mem, rs, use_rs)) begin
            return 2'b10;
        end else if (hit(wb, rs, use_rs)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    always_comb begin
        load_use = (state_q == StRun) && id_valid && ex_q.is_load &&
                   (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2));

        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        advance = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (rst) begin
            // Outputs stay quiet; the registers are cleared in the state process.
        end else if (mem_wait) begin
            stall = 1'b1;
        end else begin
            advance = 1'b1;
            if (ex_mispredict) begin
                flush = 1'b1;
                cnt_d = FlushLoad;
                // The mispredict cycle itself is the first flush cycle, so a single-cycle
                // flush never needs the FLUSH state.
                state_d = (FLUSH_CYCLES > 1) ? StFlush : StRun;
            end else if (state_q == StFlush) begin
                flush = 1'b1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end else if (load_use) begin
                stall   = 1'b1;
                bubble  = 1'b1;
                state_d = StStall;
            end else begin
                state_d = StRun;
            end
        end

        take_id = id_valid && !flush && !bubble;

        ex_d = '0;
        sel1_d = 2'b00;
        sel2_d = 2'b00;
        if (take_id) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = id_rd;
            ex_d.regwen  = id_regwen;
            ex_d.is_load = id_is_load;
            sel1_d = pick(ex_q, mem_q, wb_q, id_rs1, id_use_rs1);
            sel2_d = pick(ex_q, mem_q, wb_q, id_rs2, id_use_rs2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ret_q   <= '0;
            sel1_q  <= 2'b00;
            sel2_q  <= 2'b00;
        end else if (advance) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            ret_q   <= wb_q;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
        end
    end

    assign fwd_sel_rs1 = sel1_q;
    assign fwd_sel_rs2 = sel2_q;
    assign flush_if_id = flush;
    assign flush_id_ex = flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES = 3).
// Inputs change on the falling edge; combinational outputs are checked just after that,
// and the expected forward selects are queued and compared just after the next rising edge.

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_regwen, id_is_load;
    logic       ex_mispredict, mem_wait;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic       stall, bubble, flush_if_id, flush_id_ex;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      tag;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(3),
        .XLEN_REG    (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwen    (id_regwen),
        .id_is_load   (id_is_load),
        .ex_mispredict(ex_mispredict),
        .mem_wait     (mem_wait),
        .fwd_sel_rs1  (fwd_sel_rs1),
        .fwd_sel_rs2  (fwd_sel_rs2),
        .stall        (stall),
        .bubble       (bubble),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: each rising edge retires one expected select pair.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val({mon_e.tag, "/sel1"}, int'(fwd_sel_rs1), int'(mon_e.s1));
            check_val({mon_e.tag, "/sel2"}, int'(fwd_sel_rs2), int'(mon_e.s2));
        end
    end

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld);
        id_valid      = v;
        id_rs1        = rs1;
        id_use_rs1    = u1;
        id_rs2        = rs2;
        id_use_rs2    = u2;
        id_rd         = rd;
        id_regwen     = wen;
        id_is_load    = ld;
        ex_mispredict = 1'b0;
        mem_wait      = 1'b0;
    endtask

    task automatic nop();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check this cycle's combinational outputs, queue the select pair expected once
    // the ID contents move into EX, then advance one cycle.
    task automatic tick(input string tag, input logic e_st, input logic e_bb,
                        input logic e_fl, input logic [1:0] e1, input logic [1:0] e2);
        exp_t e;
        #1;
        check_val({tag, "/stall"}, int'(stall), int'(e_st));
        check_val({tag, "/bubble"}, int'(bubble), int'(e_bb));
        check_val({tag, "/flush_if_id"}, int'(flush_if_id), int'(e_fl));
        check_val({tag, "/flush_id_ex"}, int'(flush_id_ex), int'(e_fl));
        e.tag = tag;
        e.s1  = e1;
        e.s2  = e2;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        nop();
        repeat (4) tick(tag, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset/sel1", int'(fwd_sel_rs1), 0);
        check_val("reset/sel2", int'(fwd_sel_rs2), 0);
        check_val("reset/stall", int'(stall), 0);
        check_val("reset/flush", int'(flush_if_id), 0);
        rst = 1'b0;

        // 1: ALU back-to-back
        drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick("t1_add", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd5, 1, 5'd4, 1, 5'd6, 1, 0);
        tick("t1_sub", 0, 0, 0, 2'b01, 2'b00);
        drain("t1_drain");

        // 2: distance 2, 3, 4 and an unused source
        drv(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        tick("t2_prod", 0, 0, 0, 2'b00, 2'b00);
        nop();
        tick("t2_gap", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd7, 1, 5'd3, 1, 5'd10, 1, 0);
        tick("t2_d2", 0, 0, 0, 2'b10, 2'b00);
        drv(1, 5'd3, 1, 5'd7, 1, 5'd11, 1, 0);
        tick("t2_d3", 0, 0, 0, 2'b00, 2'b11);
        drv(1, 5'd7, 1, 5'd7, 1, 5'd12, 1, 0);
        tick("t2_d4", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd12, 0, 5'd11, 1, 5'd13, 1, 0);
        tick("t2_unused", 0, 0, 0, 2'b00, 2'b10);
        drain("t2_drain");

        // 3: load-use
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1);
        tick("t3_lw", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd3, 1, 5'd2, 1, 5'd4, 1, 0);
        tick("t3_hazard", 1, 1, 0, 2'b00, 2'b00);
        tick("t3_resume", 0, 0, 0, 2'b10, 2'b00);
        nop();
        tick("t3_after", 0, 0, 0, 2'b00, 2'b00);
        drain("t3_drain");

        // 4: x0 never forwards or stalls; younger writer wins
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        tick("t4_wx0", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0);
        tick("t4_rx0", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
        tick("t4_lwx0", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd0, 1, 5'd0, 1, 5'd16, 1, 0);
        tick("t4_rx0_ld", 0, 0, 0, 2'b00, 2'b00);
        drain("t4_drain_a");
        drv(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick("t4_w9a", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd2, 1, 5'd3, 1, 5'd9, 1, 0);
        tick("t4_w9b", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd9, 1, 5'd9, 1, 5'd15, 1, 0);
        tick("t4_r9", 0, 0, 0, 2'b01, 2'b01);
        drain("t4_drain_b");

        // 5: mispredict, FLUSH_CYCLES = 3; ID content during flush must be dropped
        drv(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 0);
        tick("t5_prod", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd8, 1, 5'd0, 0, 5'd17, 1, 0);
        ex_mispredict = 1'b1;
        tick("t5_mis", 0, 0, 1, 2'b00, 2'b00);
        drv(1, 5'd1, 1, 5'd2, 1, 5'd18, 1, 0);
        tick("t5_fl2", 0, 0, 1, 2'b00, 2'b00);
        tick("t5_fl3", 0, 0, 1, 2'b00, 2'b00);
        drv(1, 5'd18, 1, 5'd18, 1, 5'd19, 1, 0);
        tick("t5_run", 0, 0, 0, 2'b00, 2'b00);
        drain("t5_drain_a");
        nop();
        ex_mispredict = 1'b1;
        tick("t5_ext1", 0, 0, 1, 2'b00, 2'b00);
        ex_mispredict = 1'b1;
        tick("t5_ext2", 0, 0, 1, 2'b00, 2'b00);
        nop();
        tick("t5_ext3", 0, 0, 1, 2'b00, 2'b00);
        tick("t5_ext4", 0, 0, 1, 2'b00, 2'b00);
        tick("t5_ext5", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1);
        tick("t5_lw", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
        ex_mispredict = 1'b1;
        tick("t5_mis_lu", 0, 0, 1, 2'b00, 2'b00);
        nop();
        tick("t5_lu_fl2", 0, 0, 1, 2'b00, 2'b00);
        tick("t5_lu_fl3", 0, 0, 1, 2'b00, 2'b00);
        drain("t5_drain_b");

        // 6: mem_wait freeze during forwarding, then reset inside a flush
        drv(1, 5'd1, 1, 5'd2, 1, 5'd20, 1, 0);
        tick("t6_p", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd20, 1, 5'd0, 0, 5'd21, 1, 0);
        tick("t6_c", 0, 0, 0, 2'b01, 2'b00);
        for (int i = 0; i < 4; i++) begin
            drv(1, 5'd20, 1, 5'd21, 1, 5'd22, 1, 0);
            mem_wait      = 1'b1;
            ex_mispredict = (i == 1);
            tick($sformatf("t6_wait%0d", i), 1, 0, 0, 2'b01, 2'b00);
        end
        drv(1, 5'd20, 1, 5'd21, 1, 5'd22, 1, 0);
        tick("t6_release", 0, 0, 0, 2'b10, 2'b01);
        drain("t6_drain");
        nop();
        ex_mispredict = 1'b1;
        tick("t6_mis", 0, 0, 1, 2'b00, 2'b00);
        nop();
        rst = 1'b1;
        tick("t6_rst", 0, 0, 0, 2'b00, 2'b00);
        rst = 1'b0;
        tick("t6_post_rst", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd1, 1, 5'd2, 1, 5'd23, 1, 0);
        tick("t6_p2", 0, 0, 0, 2'b00, 2'b00);
        drv(1, 5'd2, 1, 5'd23, 1, 5'd24, 1, 0);
        tick("t6_c2", 0, 0, 0, 2'b00, 2'b01);
        nop();

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
